// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared states, size codes and requester ids for the memory access arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHECK   = 2'd1,
      ISSUE   = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_D  = 1'b1
   } req_id_t;

   localparam logic [1:0] DT_BYTE  = 2'b00;
   localparam logic [1:0] DT_HALF  = 2'b01;
   localparam logic [1:0] DT_WORD  = 2'b10;
   localparam logic [1:0] DT_DWORD = 2'b11;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // An access of size 2^dt bytes must start on a 2^dt byte boundary.
   function automatic logic is_misaligned(input logic [1:0] dt, input logic [2:0] lsb);
      logic bad;
      case (dt)
         DT_BYTE:  bad = 1'b0;
         DT_HALF:  bad = lsb[0];
         DT_WORD:  bad = |lsb[1:0];
         DT_DWORD: bad = |lsb;
         default:  bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// rtl/mem_access_arbiter_if.sv - MOV/MOC bus between the arbiter and the shared ram256x32
interface mem_access_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              mem_mov;
   logic              mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_dt;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_moc;

   modport master (
      output mem_mov,
      output mem_rw,
      output mem_addr,
      output mem_dt,
      output mem_wdata,
      input  mem_rdata,
      input  mem_moc
   );

   modport slave (
      input  mem_mov,
      input  mem_rw,
      input  mem_addr,
      input  mem_dt,
      input  mem_wdata,
      output mem_rdata,
      output mem_moc
   );
endinterface

// File: rtl/mem_handshake_fsm.sv
// rtl/mem_handshake_fsm.sv - access sequencing, MOV/MOC four-phase handshake and MOC timeout
module mem_handshake_fsm
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_any,
   input  logic misaligned,
   input  logic moc,
   output logic accept,
   output logic issue_start,
   output logic capture,
   output logic abort,
   output logic to_idle,
   output logic mov,
   output logic done,
   output logic err
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   arb_state_t state, state_n;
   logic [7:0] cnt, cnt_n;
   logic       mov_n, done_n, err_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         mov   <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         mov   <= mov_n;
         done  <= done_n;
         err   <= err_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      mov_n       = mov;
      done_n      = 1'b0;
      err_n       = 1'b0;
      accept      = 1'b0;
      issue_start = 1'b0;
      capture     = 1'b0;
      abort       = 1'b0;
      case (state)
         IDLE: begin
            // The done cycle still sees the finished client's request, so skip it.
            if (req_any && !done) begin
               accept  = 1'b1;
               state_n = CHECK;
            end
         end
         CHECK: begin
            if (misaligned) begin
               done_n  = 1'b1;
               err_n   = 1'b1;
               state_n = IDLE;
            end else begin
               issue_start = 1'b1;
               mov_n       = 1'b1;
               cnt_n       = '0;
               state_n     = ISSUE;
            end
         end
         ISSUE: begin
            if (moc) begin
               capture = 1'b1;
               mov_n   = 1'b0;
               cnt_n   = '0;
               state_n = RELEASE;
            end else if (cnt == CNT_LAST) begin
               abort   = 1'b1;
               mov_n   = 1'b0;
               done_n  = 1'b1;
               err_n   = 1'b1;
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         RELEASE: begin
            if (!moc) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      to_idle = (state != IDLE) && (state_n == IDLE);
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - round-robin fetch/data arbiter in front of the shared ram256x32
module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_done,
   output logic [DATA_W-1:0]     if_rdata,
   input  logic                  d_req,
   input  logic                  d_rw,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [1:0]            d_dt,
   input  logic [DATA_W-1:0]     d_wdata,
   output logic                  d_done,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  err,
   mem_access_arbiter_if.master  mem
);

   req_id_t           last_grant;
   logic [ADDR_W-1:0] req_addr;
   logic              req_rw;
   logic [1:0]        req_dt;
   logic [DATA_W-1:0] req_wdata;

   logic [ADDR_W-1:0] mem_addr_r;
   logic              mem_rw_r;
   logic [1:0]        mem_dt_r;
   logic [DATA_W-1:0] mem_wdata_r;

   logic              accept, issue_start, capture, abort, to_idle;
   logic              mov, done, fsm_err;
   logic              pick_d, misaligned;
   logic [DATA_W-1:0] result;

   // Data wins when it is alone or when fetch was served last.
   assign pick_d     = d_req && (!if_req || last_grant == REQ_IF);
   assign misaligned = is_misaligned(req_dt, req_addr[2:0]);
   assign result     = capture ? mem.mem_rdata : '0;

   mem_handshake_fsm #(
      .TIMEOUT (TIMEOUT)
   ) u_fsm (
      .clk         (clk),
      .rst_n       (clr),
      .req_any     (if_req || d_req),
      .misaligned  (misaligned),
      .moc         (mem.mem_moc),
      .accept      (accept),
      .issue_start (issue_start),
      .capture     (capture),
      .abort       (abort),
      .to_idle     (to_idle),
      .mov         (mov),
      .done        (done),
      .err         (fsm_err)
   );

   // last_grant doubles as the owner of the transfer in flight.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         last_grant <= REQ_IF;
         req_addr   <= '0;
         req_rw     <= RW_READ;
         req_dt     <= DT_WORD;
         req_wdata  <= '0;
      end else if (accept) begin
         if (pick_d) begin
            last_grant <= REQ_D;
            req_addr   <= d_addr;
            req_rw     <= d_rw;
            req_dt     <= d_dt;
            req_wdata  <= d_wdata;
         end else begin
            last_grant <= REQ_IF;
            req_addr   <= if_addr;
            req_rw     <= RW_READ;
            req_dt     <= DT_WORD;
            req_wdata  <= '0;
         end
      end
   end

   // Bus fields load only when MOV rises; the write strobe falls back to read on return to IDLE.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         mem_addr_r  <= '0;
         mem_rw_r    <= RW_READ;
         mem_dt_r    <= DT_WORD;
         mem_wdata_r <= '0;
      end else if (issue_start) begin
         mem_addr_r  <= req_addr;
         mem_rw_r    <= req_rw;
         mem_dt_r    <= req_dt;
         mem_wdata_r <= req_wdata;
      end else if (to_idle) begin
         mem_rw_r    <= RW_READ;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         if_rdata <= '0;
         d_rdata  <= '0;
      end else if ((capture || abort) && req_rw == RW_READ) begin
         if (last_grant == REQ_IF) begin
            if_rdata <= result;
         end else begin
            d_rdata  <= result;
         end
      end
   end

   assign if_done = done && (last_grant == REQ_IF);
   assign d_done  = done && (last_grant == REQ_D);
   assign err     = fsm_err;

   assign mem.mem_mov   = mov;
   assign mem.mem_rw    = mem_rw_r;
   assign mem.mem_addr  = mem_addr_r;
   assign mem.mem_dt    = mem_dt_r;
   assign mem.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - scoreboard bench for mem_access_arbiter with a behavioural RAM
module tb_mem_access_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        clr;
   logic        if_req, d_req, d_rw;
   logic [7:0]  if_addr, d_addr;
   logic [1:0]  d_dt;
   logic [31:0] d_wdata;
   logic        if_done, d_done, err;
   logic [31:0] if_rdata, d_rdata;

   always #5 clk = ~clk;

   mem_access_arbiter_if #(.ADDR_W(8), .DATA_W(32)) mbus();

   mem_access_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(15)) dut (
      .clk(clk), .clr(clr),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_dt(d_dt), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata), .err(err), .mem(mbus)
   );

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        if_q[$];
   exp_t        d_q[$];
   req_id_t     ord_q[$];
   logic [31:0] model_mem [256];
   logic [31:0] ram [256];
   logic [31:0] last_d;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   int          ram_delay, run, cur_delay, mov_rises, last_run;
   bit          ram_stall;
   bit          ram_ready = 1'b0;
   logic        lat_rw;
   logic [1:0]  lat_dt;
   logic [7:0]  lat_addr;
   logic [31:0] lat_wdata;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s act=pulse exp=none", name);
   endtask

   function automatic logic [31:0] init_word(input int i);
      if (i == 8) return 32'hE3A00001;
      return 32'(i * 40503 + 32'h1234_5678);
   endfunction

   function automatic bit misal(input logic [1:0] dt, input logic [7:0] a);
      int sz;
      sz = 1 << dt;
      return (int'(a) % sz) != 0;
   endfunction

   task automatic do_fetch(input logic [7:0] a, output int lat);
      exp_t e;
      int   t0;
      bit   got;
      e.err   = ram_stall;
      e.rdata = ram_stall ? 32'h0 : model_mem[a];
      if_q.push_back(e);
      @(posedge clk); #1;
      if_addr = a;
      if_req  = 1'b1;
      t0  = cyc;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (if_done) got = 1'b1;
      end
      lat = cyc - t0;
      chk("fetch_wait", 32'(got), 32'd1);
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   task automatic do_data(input logic rw, input logic [7:0] a, input logic [1:0] dt,
                          input logic [31:0] wd, output int lat);
      exp_t e;
      int   t0;
      bit   got;
      e.err = misal(dt, a) || ram_stall;
      if (!misal(dt, a)) begin
         if (ram_stall) begin
            if (rw) last_d = 32'h0;
         end else if (rw) begin
            last_d = model_mem[a];
         end else begin
            model_mem[a] = wd;
         end
      end
      e.rdata = last_d;
      d_q.push_back(e);
      @(posedge clk); #1;
      d_rw = rw; d_addr = a; d_dt = dt; d_wdata = wd;
      d_req = 1'b1;
      t0  = cyc;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (d_done) got = 1'b1;
      end
      lat = cyc - t0;
      chk("data_wait", 32'(got), 32'd1);
      @(posedge clk); #1;
      d_req = 1'b0;
   endtask

   // RAM: raises MOC cur_delay MOV cycles after MOV rises, drops it once MOV falls.
   always @(negedge clk) begin
      if (!clr) begin
         if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] = init_word(i);
            ram_ready = 1'b1;
         end
         mbus.mem_moc   = 1'b0;
         mbus.mem_rdata = 32'h0;
         run = 0;
      end else if (mbus.mem_mov) begin
         if (run == 0) begin
            mov_rises++;
            lat_rw    = mbus.mem_rw;
            lat_addr  = mbus.mem_addr;
            lat_dt    = mbus.mem_dt;
            lat_wdata = mbus.mem_wdata;
            cur_delay = (ram_delay > 0) ? ram_delay : int'($urandom_range(1, 4));
         end else begin
            chk("mov_addr_stable", 32'(mbus.mem_addr), 32'(lat_addr));
            chk("mov_rw_stable", 32'(mbus.mem_rw), 32'(lat_rw));
            chk("mov_dt_stable", 32'(mbus.mem_dt), 32'(lat_dt));
            chk("mov_wdata_stable", mbus.mem_wdata, lat_wdata);
         end
         run++;
         if (!mbus.mem_moc && !ram_stall && run >= cur_delay) begin
            mbus.mem_moc = 1'b1;
            if (mbus.mem_rw) mbus.mem_rdata = ram[mbus.mem_addr];
            else ram[mbus.mem_addr] = mbus.mem_wdata;
         end
      end else begin
         if (run > 0) last_run = run;
         run = 0;
         mbus.mem_moc = 1'b0;
      end
   end

   exp_t em;
   always @(negedge clk) begin
      if (clr) begin
         if (if_done || d_done) begin
            chk("done_exclusive", 32'(if_done & d_done), 32'd0);
            chk("moc_low_at_done", 32'(mbus.mem_moc), 32'd0);
         end
         if (err) chk("err_with_done", 32'(if_done | d_done), 32'd1);
         if (if_done) begin
            if (if_q.size() == 0) fail("if_unexpected_done");
            else begin
               em = if_q.pop_front();
               chk("if_err", 32'(err), 32'(em.err));
               chk("if_rdata", if_rdata, em.rdata);
            end
            if (ord_q.size() > 0) chk("grant_order", 32'(REQ_IF), 32'(ord_q.pop_front()));
         end
         if (d_done) begin
            if (d_q.size() == 0) fail("d_unexpected_done");
            else begin
               em = d_q.pop_front();
               chk("d_err", 32'(err), 32'(em.err));
               chk("d_rdata", d_rdata, em.rdata);
            end
            if (ord_q.size() > 0) chk("grant_order", 32'(REQ_D), 32'(ord_q.pop_front()));
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_mov"}, 32'(mbus.mem_mov), 32'd0);
      chk({tag, "_rw"}, 32'(mbus.mem_rw), 32'd1);
      chk({tag, "_addr"}, 32'(mbus.mem_addr), 32'd0);
      chk({tag, "_dt"}, 32'(mbus.mem_dt), 32'(DT_WORD));
      chk({tag, "_wdata"}, mbus.mem_wdata, 32'd0);
      chk({tag, "_done"}, 32'({if_done, d_done, err}), 32'd0);
      chk({tag, "_if_rdata"}, if_rdata, 32'd0);
      chk({tag, "_d_rdata"}, d_rdata, 32'd0);
   endtask

   int          lat, l1, l2, r0, lf, ld;
   bit          got;
   logic        drw;
   logic [1:0]  ddt;
   logic [7:0]  da, fa;
   logic [31:0] dwd;

   initial begin
      clr = 1'b0;
      if_req = 1'b0; if_addr = 8'h0;
      d_req = 1'b0; d_rw = 1'b1; d_addr = 8'h0; d_dt = DT_WORD; d_wdata = 32'h0;
      ram_delay = 0; ram_stall = 1'b0; mov_rises = 0; last_run = 0; run = 0; cur_delay = 1;
      for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
      last_d = 32'h0;
      repeat (3) @(posedge clk); #1;
      chk_reset_outputs("reset");
      clr = 1'b1;

      // Simultaneous requests after reset: data first, then alternating.
      for (int r = 0; r < 3; r++) begin
         ord_q.push_back(REQ_D);
         ord_q.push_back(REQ_IF);
         fork
            do_fetch(8'(4 * (r + 1)), l1);
            do_data(RW_READ, 8'(8'h40 + 4 * r), DT_WORD, 32'h0, l2);
         join
      end
      chk("rr_drained", 32'(ord_q.size()), 32'd0);

      ram_delay = 2;
      r0 = mov_rises;
      do_fetch(8'h08, lat);
      chk("fetch_latency", 32'(lat), 32'd5);
      chk("fetch_one_mov", 32'(mov_rises - r0), 32'd1);
      chk("fetch_mem_rw", 32'(lat_rw), 32'd1);
      chk("fetch_mem_dt", 32'(lat_dt), 32'(DT_WORD));
      chk("fetch_word", if_rdata, 32'hE3A00001);

      do_data(RW_WRITE, 8'h10, DT_WORD, 32'hDEADBEEF, lat);
      chk("store_mem_rw", 32'(lat_rw), 32'd0);
      chk("store_mem_wdata", lat_wdata, 32'hDEADBEEF);
      chk("store_latency", 32'(lat), 32'd5);
      do_data(RW_READ, 8'h10, DT_WORD, 32'h0, lat);
      chk("store_readback", d_rdata, 32'hDEADBEEF);

      r0 = mov_rises;
      do_data(RW_READ, 8'h03, DT_HALF, 32'h0, lat);
      chk("misalign_latency", 32'(lat), 32'd2);
      chk("misalign_no_mov", 32'(mov_rises - r0), 32'd0);
      chk("misalign_rdata_kept", d_rdata, 32'hDEADBEEF);

      ram_stall = 1'b1;
      do_data(RW_READ, 8'h84, DT_WORD, 32'h0, lat);
      ram_stall = 1'b0;
      chk("timeout_mov_cycles", 32'(last_run), 32'd15);
      chk("timeout_latency", 32'(lat), 32'd17);
      chk("timeout_rdata", d_rdata, 32'h0);
      do_data(RW_READ, 8'h10, DT_WORD, 32'h0, lat);
      chk("after_timeout", d_rdata, 32'hDEADBEEF);

      // Reset in the middle of a stalled transfer.
      ram_stall = 1'b1;
      @(posedge clk); #1;
      if_addr = 8'h20;
      if_req  = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (mbus.mem_mov) got = 1'b1;
      end
      chk("rst_mov_seen", 32'(got), 32'd1);
      @(negedge clk); #2;
      clr = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      if_req = 1'b0;
      last_d = 32'h0;
      ram_stall = 1'b0;
      repeat (2) @(posedge clk); #1;
      clr = 1'b1;
      do_fetch(8'h20, lat);
      chk("post_reset_latency", 32'(lat), 32'd5);

      ram_delay = 0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               fa = 8'($urandom_range(0, 31) * 4);
               do_fetch(fa, lf);
            end
         end
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               drw = 1'($urandom_range(0, 1));
               ddt = 2'($urandom_range(0, 3));
               da  = 8'h80 | 8'($urandom_range(0, 127));
               dwd = $urandom;
               do_data(drw, da, ddt, dwd, ld);
            end
         end
      join

      repeat (5) @(posedge clk);
      chk("if_queue_empty", 32'(if_q.size()), 32'd0);
      chk("d_queue_empty", 32'(d_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Sits between the CPU's two memory clients, instruction fetch and data load/store, and the single shared ram256x32.
- Arbitrates between the two clients and owns the 4-phase MOV/MOC handshake.
- Checks alignment and enforces a MOC timeout.
- Returns read data and a one-cycle done pulse to the granted client.

Parameters:
- ADDR_W, 8, memory address width (matches the 256-entry RAM).
- DATA_W, 32, data width.
- TIMEOUT, 15, maximum cycles MOV may wait for MOC before the access aborts (valid range 2..255).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_done.
- if_addr  in  ADDR_W  fetch address; always a word access.
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  DATA_W  fetched word; holds until the next fetch completes.
- d_req  in  1  data request; held with d_* until d_done.
- d_rw  in  1  1 = read, 0 = write (same sense as R_W).
- d_addr  in  ADDR_W  data address.
- d_dt  in  2  size: 00 byte, 01 halfword, 10 word, 11 doubleword.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  one-cycle pulse: data access complete.
- d_rdata  out  DATA_W  load data; holds until the next data completion.
- err  out  1  one-cycle pulse, coincident with the done pulse, for a misalignment or timeout.
- mem_mov  out  1  memory operation valid (MOV).
- mem_rw  out  1  R_W to RAM.
- mem_addr  out  ADDR_W  RAM address.
- mem_dt  out  2  RAM data type.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.
- mem_moc  in  1  memory operation complete (MOC).

Behaviour:
- Reset (clr = 0, asynchronous):
  - State IDLE; last_grant = fetch.
  - mem_mov = 0, mem_rw = 1, mem_addr = 0, mem_dt = 10, mem_wdata = 0.
  - if_done = d_done = err = 0; if_rdata = d_rdata = 0; timeout counter = 0.
  - Reset during a transfer drops MOV immediately and emits no done pulse.
- States: IDLE -> CHECK -> ISSUE -> RELEASE -> IDLE. A misaligned access goes CHECK -> IDLE; a timeout goes ISSUE -> IDLE.
- IDLE:
  - Sample the requests. If only one is asserted, grant it.
  - If both are asserted, grant the one not granted last (round-robin), so neither client starves.
  - Register the granted address, rw, dt and wdata; go to CHECK.
  - Fetch always uses rw = 1, dt = 10.
- CHECK (1 cycle), alignment rules:
  - Halfword requires addr[0] = 0.
  - Word requires addr[1:0] = 0.
  - Doubleword requires addr[2:0] = 0.
  - On a violation: no RAM access, pulse done and err for the granted client, return to IDLE, leave rdata unchanged.
  - Otherwise go to ISSUE.
- ISSUE:
  - Assert mem_mov with the registered address, rw, dt and wdata held stable; the counter increments each cycle.
  - On mem_moc = 1: capture mem_rdata into the client's rdata (reads only), deassert mem_mov next edge, go to RELEASE.
  - If the counter reaches TIMEOUT without MOC: deassert mem_mov, pulse done and err, set rdata = 0 for reads, go to IDLE.
- RELEASE:
  - Wait for mem_moc = 0, then pulse the client's done and go to IDLE.
  - Done is never pulsed while MOC is still high.
- Latency: an aligned access with MOC returned after k cycles of MOV has done asserted k + 3 cycles after the grant (MOC dropping in the cycle after MOV falls).
- A new grant cannot occur in the same cycle as a done pulse. The earliest new grant is the cycle after done, with IDLE sampling at that point.
- Requests deasserted early (before done) are a protocol violation. The transfer completes regardless.
- mem_addr and mem_dt hold their last values outside ISSUE. mem_rw returns to 1 in IDLE so stray RAM writes are impossible.

Decomposition:
- Package mem_arb_pkg:
  - State encoding (IDLE, CHECK, ISSUE, RELEASE).
  - DT constants (DT_BYTE, DT_HALF, DT_WORD, DT_DWORD).
  - Requester IDs (REQ_IF, REQ_D).
  - RW_READ = 1, RW_WRITE = 0.
- One sub-module, mem_handshake_fsm: owns the ISSUE/RELEASE sequencing and the timeout counter. The top level holds arbitration, the alignment check and the result registers.

Test Plan:
- Single fetch at if_addr = 0x08, RAM returns 0xE3A00001 with MOC after 2 cycles -> one mem_mov assertion, mem_rw = 1, mem_dt = 10, if_done pulse, if_rdata = 0xE3A00001, err = 0.
- Word store d_addr = 0x10, d_wdata = 0xDEADBEEF -> mem_rw = 0 with mem_wdata stable for the whole MOV window; d_done pulses only after MOC falls; a readback gives 0xDEADBEEF.
- if_req and d_req raised together three times in succession -> grants alternate (the first goes to data, since last_grant = fetch after reset); each client completes exactly once per grant.
- Halfword read at d_addr = 0x03 -> no mem_mov ever asserted; d_done and err pulse together 2 cycles after the request; d_rdata unchanged.
- MOC tied low with TIMEOUT = 15 -> mem_mov high for exactly 15 cycles, then d_done + err, d_rdata = 0; the next request is served normally.
- clr pulsed low mid-ISSUE -> mem_mov falls asynchronously, no done pulse, all outputs at their reset values; after release a fresh fetch completes normally.
